// File: rtl/mux_scan_seq_if.sv
// Signal bundle between the scan sequencer and the keyed mux / board logic.
// MUX_SCAN_MASK_EN adds the ch_mask channel-enable vector.
interface mux_scan_seq_if;
   logic       en;
   logic [1:0] mux_out;
`ifdef MUX_SCAN_MASK_EN
   logic [3:0] ch_mask;
`endif
   logic [1:0] sel;
   logic [1:0] ch0;
   logic [1:0] ch1;
   logic [1:0] ch2;
   logic [1:0] ch3;
   logic [3:0] ch_valid;
   logic       change;
   logic       frame_done;
   logic       busy;

`ifdef MUX_SCAN_MASK_EN
   modport master (
      input  en, mux_out, ch_mask,
      output sel, ch0, ch1, ch2, ch3, ch_valid, change, frame_done, busy
   );
   modport slave (
      output en, mux_out, ch_mask,
      input  sel, ch0, ch1, ch2, ch3, ch_valid, change, frame_done, busy
   );
`else
   modport master (
      input  en, mux_out,
      output sel, ch0, ch1, ch2, ch3, ch_valid, change, frame_done, busy
   );
   modport slave (
      output en, mux_out,
      input  sel, ch0, ch1, ch2, ch3, ch_valid, change, frame_done, busy
   );
`endif
endinterface

// File: rtl/mux_scan_seq.sv
// Round-robin scanner for the 4-to-1 keyed mux: settle DWELL cycles, sample, advance.
// MUX_SCAN_MASK_EN restricts the scan to channels enabled in ch_mask.
//
// state  | meaning
// IDLE   | not scanning, sel held so a restart resumes on the same channel
// SETTLE | waiting DWELL cycles for mux_out to settle after a sel change
// SAMPLE | one cycle: capture mux_out into the current channel, advance sel
module mux_scan_seq #(
   parameter int DWELL = 4,
   parameter int CNT_W = $clog2(DWELL + 1)
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_seq_if.master bus
);

   if (DWELL < 1) begin : g_dwell_chk
      $error("mux_scan_seq: DWELL must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0][1:0]  ch_q, ch_d;
   logic [3:0]       valid_q, valid_d;
   logic             change_q, change_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;

   logic             scan_ok;
   logic [1:0]       adv_sel;
   logic [1:0]       start_sel;
   logic             last_ch;

`ifdef MUX_SCAN_MASK_EN
   // Nearest enabled channel strictly after cur (wrapping back to cur itself).
   function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
      logic [1:0] idx;
      next_ch = cur;
      for (int i = 4; i >= 1; i--) begin
         idx = cur + 2'(i);
         if (mask[idx]) next_ch = idx;
      end
   endfunction

   function automatic logic [1:0] hi_ch(input logic [3:0] mask);
      hi_ch = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) hi_ch = 2'(i);
      end
   endfunction

   assign scan_ok   = |bus.ch_mask;
   assign adv_sel   = next_ch(sel_q, bus.ch_mask);
   assign start_sel = bus.ch_mask[sel_q] ? sel_q : adv_sel;
   assign last_ch   = scan_ok && (sel_q == hi_ch(bus.ch_mask));
`else
   assign scan_ok   = 1'b1;
   assign adv_sel   = sel_q + 2'd1;
   assign start_sel = sel_q;
   assign last_ch   = (sel_q == 2'd3);
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      ch_d         = ch_q;
      valid_d      = valid_q;
      change_d     = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.en && scan_ok) begin
               state_d = SETTLE;
               cnt_d   = '0;
               sel_d   = start_sel;
            end
         end
         SETTLE: begin
            if (!bus.en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         SAMPLE: begin
            // The sample is committed even if en has just dropped.
            ch_d[sel_q]    = bus.mux_out;
            valid_d[sel_q] = 1'b1;
            change_d       = valid_q[sel_q] && (bus.mux_out != ch_q[sel_q]);
            frame_done_d   = last_ch;
            sel_d          = adv_sel;
            cnt_d          = '0;
            state_d        = (bus.en && scan_ok) ? SETTLE : IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sel_q        <= 2'd0;
         ch_q         <= '0;
         valid_q      <= 4'd0;
         change_q     <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         ch_q         <= ch_d;
         valid_q      <= valid_d;
         change_q     <= change_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.ch0        = ch_q[0];
   assign bus.ch1        = ch_q[1];
   assign bus.ch2        = ch_q[2];
   assign bus.ch3        = ch_q[3];
   assign bus.ch_valid   = valid_q;
   assign bus.change     = change_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq; models the mux from sel and scoreboards every sample.
// Build with MUX_SCAN_MASK_EN to add the masked-scan steps.
module tb_mux_scan_seq;
   localparam int DWELL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux_scan_seq_if bus_if ();

   logic [1:0] x [4];
   assign bus_if.mux_out = x[bus_if.sel];

   mux_scan_seq #(.DWELL(DWELL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [1:0] ch;
      logic [1:0] val;
      logic       chg;
      logic       fd;
      logic [1:0] nsel;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] ch, input logic [1:0] val, input logic chg,
                       input logic fd, input logic [1:0] nsel);
      exp_t e;
      e.ch = ch; e.val = val; e.chg = chg; e.fd = fd; e.nsel = nsel;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] ch_of(input logic [1:0] n);
      case (n)
         2'd0:    ch_of = bus_if.ch0;
         2'd1:    ch_of = bus_if.ch1;
         2'd2:    ch_of = bus_if.ch2;
         default: ch_of = bus_if.ch3;
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"},   32'(bus_if.sel), 32'd0);
      check({tag, "_ch"},    32'({bus_if.ch3, bus_if.ch2, bus_if.ch1, bus_if.ch0}), 32'd0);
      check({tag, "_valid"}, 32'(bus_if.ch_valid), 32'd0);
      check({tag, "_busy"},  32'(bus_if.busy), 32'd0);
      check({tag, "_pulse"}, 32'({bus_if.change, bus_if.frame_done}), 32'd0);
   endtask

   // Sample monitor: a sample is seen as a sel move while the scanner was busy.
   logic       rst_at_edge = 1'b1;
   logic [1:0] prev_sel    = 2'd0;
   logic       prev_busy   = 1'b0;
   always @(posedge clk) rst_at_edge <= rst;

   always @(negedge clk) begin
      if (!rst_at_edge) begin
         if (bus_if.sel !== prev_sel && prev_busy) begin
            if (sb.size() == 0) begin
               check("unexpected_sel_move", 32'(bus_if.sel), 32'(prev_sel));
            end else begin
               mon_e = sb.pop_front();
               check("smp_ch",         32'(prev_sel), 32'(mon_e.ch));
               check("smp_val",        32'(ch_of(mon_e.ch)), 32'(mon_e.val));
               check("smp_valid",      32'(bus_if.ch_valid[mon_e.ch]), 32'd1);
               check("smp_change",     32'(bus_if.change), 32'(mon_e.chg));
               check("smp_frame_done", 32'(bus_if.frame_done), 32'(mon_e.fd));
               check("smp_next_sel",   32'(bus_if.sel), 32'(mon_e.nsel));
            end
         end else begin
            check("quiet_change",     32'(bus_if.change), 32'd0);
            check("quiet_frame_done", 32'(bus_if.frame_done), 32'd0);
         end
      end
      prev_sel  = bus_if.sel;
      prev_busy = bus_if.busy;
   end

   initial begin
      x[0] = 2'd1; x[1] = 2'd2; x[2] = 2'd3; x[3] = 2'd0;
      bus_if.en = 1'b1;
`ifdef MUX_SCAN_MASK_EN
      bus_if.ch_mask = 4'hF;
`endif
      rst = 1'b1;
      tick(2);
      check_reset_outputs("reset");
      rst = 1'b0;
      bus_if.en = 1'b0;
      tick(2);
      check("idle_busy", 32'(bus_if.busy), 32'd0);

      // Frame 1
      push(2'd0, 2'd1, 1'b0, 1'b0, 2'd1);
      push(2'd1, 2'd2, 1'b0, 1'b0, 2'd2);
      push(2'd2, 2'd3, 1'b0, 1'b0, 2'd3);
      push(2'd3, 2'd0, 1'b0, 1'b1, 2'd0);
      bus_if.en = 1'b1;
      tick(1);
      check("start_busy", 32'(bus_if.busy), 32'd1);
      check("start_sel",  32'(bus_if.sel), 32'd0);
      tick(4);
      check("ch0_before_sample", 32'(bus_if.ch0), 32'd0);
      check("sel_hold_0",        32'(bus_if.sel), 32'd0);
      tick(1);
      check("ch0_at_cycle6", 32'(bus_if.ch0), 32'd1);
      check("sel_step_1",    32'(bus_if.sel), 32'd1);
      tick(5);
      check("sel_step_2", 32'(bus_if.sel), 32'd2);
      tick(5);
      check("sel_step_3", 32'(bus_if.sel), 32'd3);
      tick(4);
      check("fd_early", 32'(bus_if.frame_done), 32'd0);
      tick(1);
      check("fd_cycle21",  32'(bus_if.frame_done), 32'd1);
      check("sel_wrap",    32'(bus_if.sel), 32'd0);
      check("valid_full",  32'(bus_if.ch_valid), 32'hF);

      // Frame 2 with channel 2 changed
      x[2] = 2'd1;
      push(2'd0, 2'd1, 1'b0, 1'b0, 2'd1);
      push(2'd1, 2'd2, 1'b0, 1'b0, 2'd2);
      push(2'd2, 2'd1, 1'b1, 1'b0, 2'd3);
      push(2'd3, 2'd0, 1'b0, 1'b1, 2'd0);
      tick(1);
      check("fd_one_cycle", 32'(bus_if.frame_done), 32'd0);
      tick(14);
      check("change_ch2",   32'(bus_if.change), 32'd1);
      check("ch2_updated",  32'(bus_if.ch2), 32'd1);
      tick(1);
      check("change_one_cycle", 32'(bus_if.change), 32'd0);
      tick(4);
      check("fd_frame2", 32'(bus_if.frame_done), 32'd1);

      // Abort during channel 1 settle
      push(2'd0, 2'd1, 1'b0, 1'b0, 2'd1);
      tick(5);
      check("abort_pre_sel", 32'(bus_if.sel), 32'd1);
      tick(2);
      bus_if.en = 1'b0;
      tick(1);
      check("abort_busy", 32'(bus_if.busy), 32'd0);
      check("abort_sel",  32'(bus_if.sel), 32'd1);
      check("abort_ch1",  32'(bus_if.ch1), 32'd2);
      tick(3);
      check("abort_hold_sel", 32'(bus_if.sel), 32'd1);
      check("abort_hold_ch1", 32'(bus_if.ch1), 32'd2);
      x[1] = 2'd3;
      push(2'd1, 2'd3, 1'b1, 1'b0, 2'd2);
      bus_if.en = 1'b1;
      tick(5);
      check("resume_ch1_before", 32'(bus_if.ch1), 32'd2);
      tick(1);
      check("resume_ch1_after", 32'(bus_if.ch1), 32'd3);
      check("resume_sel",       32'(bus_if.sel), 32'd2);

      // Reset landing on channel 3's SAMPLE cycle
      push(2'd2, 2'd1, 1'b0, 1'b0, 2'd3);
      tick(5);
      check("pre_rst_sel", 32'(bus_if.sel), 32'd3);
      tick(4);
      rst = 1'b1;
      tick(1);
      check_reset_outputs("rst_in_sample");
      rst = 1'b0;
      bus_if.en = 1'b0;
      tick(2);
      check("sb_drained", 32'(sb.size()), 32'd0);

`ifdef MUX_SCAN_MASK_EN
      x[0] = 2'd1; x[1] = 2'd2; x[2] = 2'd3; x[3] = 2'd1;
      bus_if.ch_mask = 4'b1010;
      push(2'd1, 2'd2, 1'b0, 1'b0, 2'd3);
      push(2'd3, 2'd1, 1'b0, 1'b1, 2'd1);
      push(2'd1, 2'd2, 1'b0, 1'b0, 2'd3);
      push(2'd3, 2'd1, 1'b0, 1'b1, 2'd1);
      bus_if.en = 1'b1;
      tick(1);
      check("mask_start_sel", 32'(bus_if.sel), 32'd1);
      tick(5);
      check("mask_ch1",  32'(bus_if.ch1), 32'd2);
      check("mask_sel3", 32'(bus_if.sel), 32'd3);
      tick(5);
      check("mask_fd", 32'(bus_if.frame_done), 32'd1);
      tick(10);
      check("mask_fd2",   32'(bus_if.frame_done), 32'd1);
      check("mask_ch02",  32'({bus_if.ch2, bus_if.ch0}), 32'd0);
      check("mask_valid", 32'(bus_if.ch_valid), 32'b1010);
      tick(1);
      bus_if.ch_mask = 4'b0000;
      tick(4);
      check("mask0_busy", 32'(bus_if.busy), 32'd0);
      check("mask0_sel",  32'(bus_if.sel), 32'd1);
      tick(2);
      check("mask0_stay_idle", 32'(bus_if.busy), 32'd0);
      check("mask_sb_drained", 32'(sb.size()), 32'd0);
      bus_if.en = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Upstream sequencer for the 4-to-1, 2-bit keyed mux.
- Drives the mux select round-robin over channels 0..3 and waits a programmable settle time on each channel.
- Samples the mux output into per-channel holding registers.
- Flags value changes and frame completion. Turns the combinational mux into a time-multiplexed scanner for the lab board.

Parameters:
- DWELL, 4: settle cycles per channel before sampling. Legal range >=1; DWELL=0 triggers an elaboration error.
- CNT_W, $clog2(DWELL+1): settle counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable, level-sensitive.
- mux_out  input  2  mux output for the currently driven select.
- sel  output  2  select driven to the mux key input.
- ch0  output  2  last sampled value of channel 0.
- ch1  output  2  last sampled value of channel 1.
- ch2  output  2  last sampled value of channel 2.
- ch3  output  2  last sampled value of channel 3.
- ch_valid  output  4  bit n set once channel n has been sampled since reset.
- change  output  1  one-cycle pulse: the sampled value differs from the previous valid sample of that channel.
- frame_done  output  1  one-cycle pulse after channel 3 is sampled.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state updates on rising clk; rst sampled on rising clk, which is the only reset.
- Reset values: state=IDLE, sel=0, cnt=0, ch0..ch3=0, ch_valid=0, change=0, frame_done=0, busy=0.
- All outputs registered; no combinational path from mux_out or en to any output.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - en=1 -> SETTLE, cnt<=0.
  - sel holds its current value; scanning resumes from the held channel.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==DWELL-1 -> SAMPLE. Total DWELL cycles in SETTLE.
  - en=0 -> IDLE at the next edge, cnt<=0, sel held, no sample taken.
- SAMPLE (exactly one cycle):
  - ch[sel]<=mux_out; ch_valid[sel]<=1.
  - change<=1 iff ch_valid[sel] was already 1 and mux_out != old ch[sel]. The first sample of a channel never raises change.
  - frame_done<=1 iff sel==3.
  - sel<=sel+1, wrapping 3->0 (2-bit modulo).
  - Next state: en=1 -> SETTLE, cnt<=0; en=0 -> IDLE. The sample is still taken when en falls during SAMPLE.
- Pulse timing: change and frame_done are high in the cycle following SAMPLE, coincident with the updated chN. Otherwise 0.
- Timing:
  - sel is stable for DWELL+1 cycles per channel.
  - Per-channel period is DWELL+1 cycles; frame period is 4*(DWELL+1) cycles.
  - First sample of ch0 is visible DWELL+2 cycles after en rises from IDLE.
- rst mid-scan overrides everything, including a SAMPLE in the same cycle: the cycle after, all outputs are at reset values.
- mux_out is assumed stable within DWELL cycles of a sel change. The block never samples in the same cycle sel changes.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input port ch_mask [3:0]; bit n=1 includes channel n in the scan.
  - On advance, sel jumps to the next set mask bit after sel, in ascending order with wrap.
  - On leaving IDLE, if ch_mask[sel]=0, sel first jumps to the next set bit in the same edge that enters SETTLE.
  - frame_done pulses after sampling the highest-index enabled channel.
  - ch_mask==0: the FSM stays in or returns to IDLE, busy=0, registers hold.
  - ch_mask is sampled only at channel advance and on IDLE exit.
- Not defined:
  - No ch_mask port.
  - All four channels are scanned with plain 2-bit wrap.

Test Plan (DWELL=4, bench models the mux from sel):
- Reset: assert rst 2 cycles with en=1 -> sel=0, ch0..ch3=0, ch_valid=0, busy=0, no pulses.
- Full frame: inputs x0..x3=1,2,3,0; en=1 -> ch0=1 at cycle 6 after en. sel sequence 0,1,2,3,0 with 5-cycle steps. frame_done single pulse at cycle 21, ch_valid=4'hF, change never asserted.
- Change detect: second frame with x2 changed 3->1 -> change pulses exactly once, coincident with ch2 updating to 1. Other channels give no pulse.
- Abort: drop en at cycle 3 of SETTLE on channel 1 -> IDLE next edge, sel stays 1, ch1 unchanged. Re-raise en -> ch1 sampled DWELL+2 cycles later.
- Reset mid-SAMPLE: assert rst in the SAMPLE cycle of channel 3 -> no frame_done, all outputs at reset values.
- MUX_SCAN_MASK_EN, ch_mask=4'b1010 -> sel alternates 1,3,1,3; frame_done after each ch3 sample; ch0/ch2 stay 0. Setting ch_mask=0 -> busy=0 within one channel period.
